branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline. It predicts branch and JAL redirects in IF, where the current core only resolves branches in ID and flushes IF/ID on every taken branch.
- Combines a direct-mapped BTB with a table of 2-bit saturating counters.
- Counter table is indexed bimodally or gshare-style, selected by MODE.
- Training is non-speculative, from ID-stage resolution.
- Exposes lookup and mispredict statistics for the debug path.

---
 rtl/branch_predictor_if.sv | 34 +++
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and ID-side training signals of the dynamic branch predictor.
// master = pipeline (IF/ID stages), slave = predictor.
interface branch_predictor_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 6
);
  logic             lookup_en;
  logic [XLEN-1:0]  lookup_pc;
  logic             pred_taken;
  logic [XLEN-1:0]  pred_target;
  logic [IDX_W-1:0] pred_idx;

  logic             update_valid;
  logic [XLEN-1:0]  update_pc;
  logic [IDX_W-1:0] update_idx;
  logic             update_is_jump;
  logic             update_taken;
  logic [XLEN-1:0]  update_target;
  logic             update_mispredict;

  modport master (
    output lookup_en, lookup_pc,
    output update_valid, update_pc, update_idx, update_is_jump,
    output update_taken, update_target, update_mispredict,
    input  pred_taken, pred_target, pred_idx
  );

  modport slave (
    input  lookup_en, lookup_pc,
    input  update_valid, update_pc, update_idx, update_is_jump,
    input  update_taken, update_target, update_mispredict,
    output pred_taken, pred_target, pred_idx
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB plus 2-bit (CNT_W-bit) saturating counters, bimodal or gshare indexed.
// Predicts combinationally in IF; trains one cycle later from ID-stage resolution.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 10,
  parameter int MODE    = 0,
  parameter int CNT_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  branch_predictor_if.slave bp,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  // Weakly-not-taken start value and saturation ceiling of each counter.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [ENTRIES-1:0] btb_valid;
  logic [ENTRIES-1:0] btb_jump;
  logic [TAG_W-1:0]   btb_tag    [ENTRIES];
  logic [XLEN-1:0]    btb_target [ENTRIES];
  logic [CNT_W-1:0]   cnt_tab    [ENTRIES];
  logic [IDX_W-1:0]   ghr;

  // ---------------------------------------------------------------------------
  // Lookup: purely combinational; table state is the pre-update value, so a
  // same-cycle training write is only visible from the next cycle on.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] lk_bi;
  logic [IDX_W-1:0] lk_ci;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic             lk_taken;

  always_comb begin
    lk_bi  = bp.lookup_pc[2 +: IDX_W];
    lk_tag = bp.lookup_pc[2 + IDX_W +: TAG_W];
    if (MODE == 1) begin
      lk_ci = lk_bi ^ ghr;
    end else begin
      lk_ci = lk_bi;
    end
    lk_hit   = btb_valid[lk_bi] && (btb_tag[lk_bi] == lk_tag);
    lk_taken = lk_hit && (btb_jump[lk_bi] || cnt_tab[lk_ci][CNT_W-1]);
  end

  assign bp.pred_taken  = lk_taken;
  assign bp.pred_target = lk_taken ? btb_target[lk_bi] : bp.lookup_pc + XLEN'(4);
  assign bp.pred_idx    = lk_ci;

  // ---------------------------------------------------------------------------
  // Training decode. Conditional branches move their counter and the history;
  // JAL only (re)writes its BTB entry. Not-taken branches never allocate.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] up_bi;
  logic [TAG_W-1:0] up_tag;
  logic             up_btb_we;
  logic             up_cnt_we;
  logic [CNT_W-1:0] up_cnt_cur;
  logic [CNT_W-1:0] up_cnt_next;

  // NOTE: every signal gets a value before any conditional update so the
  // block stays combinational and no latch is inferred.
  always_comb begin
    up_bi       = bp.update_pc[2 +: IDX_W];
    up_tag      = bp.update_pc[2 + IDX_W +: TAG_W];
    up_btb_we   = bp.update_valid && (bp.update_is_jump || bp.update_taken);
    up_cnt_we   = bp.update_valid && !bp.update_is_jump;
    up_cnt_cur  = cnt_tab[bp.update_idx];
    up_cnt_next = up_cnt_cur;
    if (bp.update_taken) begin
      if (up_cnt_cur != CNT_MAX) begin
        up_cnt_next = up_cnt_cur + CNT_W'(1);
      end
    end else begin
      if (up_cnt_cur != '0) begin
        up_cnt_next = up_cnt_cur - CNT_W'(1);
      end
    end
  end

  // NOTE: only valid bits, counters and history are reset; tag and target
  // storage is don't-care behind a cleared valid bit and stays reset-free.
  // While rst_n is low the reset branch wins, so an in-flight update is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_valid <= '0;
      btb_jump  <= '0;
      ghr       <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_tab[i] <= CNT_INIT;
      end
    end else begin
      if (up_btb_we) begin
        btb_valid[up_bi]  <= 1'b1;
        btb_jump[up_bi]   <= bp.update_is_jump;
        btb_tag[up_bi]    <= up_tag;
        btb_target[up_bi] <= bp.update_target;
      end
      if (up_cnt_we) begin
        cnt_tab[bp.update_idx] <= up_cnt_next;
        ghr                    <= {ghr[IDX_W-2:0], bp.update_taken};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debug statistics, free-running and wrapping modulo 2^32.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lookups     <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (bp.lookup_en) begin
        stat_lookups <= stat_lookups + 32'd1;
      end
      if (bp.update_valid && bp.update_mispredict) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench: one bimodal and one gshare predictor, directed steps
// followed by random traffic, both compared against a table-level reference model.
module tb_branch_predictor;

  localparam int XLEN = 32;
  localparam int ENT  = 64;
  localparam int IW   = 6;
  localparam int TW   = 10;
  localparam int CW   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(XLEN), .IDX_W(IW)) if0 ();
  branch_predictor_if #(.XLEN(XLEN), .IDX_W(IW)) if1 ();

  logic [31:0] stat_lk0, stat_mp0, stat_lk1, stat_mp1;

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENT), .TAG_W(TW), .MODE(0), .CNT_W(CW)) dut0 (
    .clk              (clk),
    .rst_n            (rst_n),
    .bp               (if0.slave),
    .stat_lookups     (stat_lk0),
    .stat_mispredicts (stat_mp0)
  );

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENT), .TAG_W(TW), .MODE(1), .CNT_W(CW)) dut1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .bp               (if1.slave),
    .stat_lookups     (stat_lk1),
    .stat_mispredicts (stat_mp1)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: one row per predictor instance, plain integer arithmetic.
  bit          m_v   [2][ENT];
  bit          m_j   [2][ENT];
  int unsigned m_tag [2][ENT];
  logic [31:0] m_tgt [2][ENT];
  int          m_cnt [2][ENT];
  int          m_ghr [2];
  int unsigned m_lk  [2];
  int unsigned m_mp  [2];

  bit          e_taken;
  logic [31:0] e_target;
  int          e_idx;
  bit          last_taken;
  logic [31:0] last_target;
  int          last_idx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic int unsigned tagof(input logic [31:0] pc);
    return (pc / (4 * ENT)) % (1 << TW);
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < ENT; i++) begin
        m_v[m][i]   = 1'b0;
        m_j[m][i]   = 1'b0;
        m_cnt[m][i] = (1 << (CW - 1)) - 1;
      end
      m_ghr[m] = 0;
      m_lk[m]  = 0;
      m_mp[m]  = 0;
    end
  endfunction

  function automatic void model_predict(input int m, input logic [31:0] pc,
                                        output bit tk, output logic [31:0] tg, output int ix);
    int  b;
    bit  hit;
    b   = bidx(pc);
    ix  = (m == 1) ? (b ^ m_ghr[m]) : b;
    hit = m_v[m][b] && (m_tag[m][b] == tagof(pc));
    tk  = hit && (m_j[m][b] || (m_cnt[m][ix] >= (1 << (CW - 1))));
    tg  = tk ? m_tgt[m][b] : pc + 32'd4;
  endfunction

  function automatic void model_train(input int m, input logic [31:0] upc, input int uidx,
                                      input bit uj, input bit ut, input logic [31:0] utg);
    int b;
    b = bidx(upc);
    if (!uj) begin
      if (ut) m_cnt[m][uidx] = (m_cnt[m][uidx] + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : m_cnt[m][uidx] + 1;
      else    m_cnt[m][uidx] = (m_cnt[m][uidx] - 1 < 0) ? 0 : m_cnt[m][uidx] - 1;
      m_ghr[m] = (m_ghr[m] * 2 + int'(ut)) % ENT;
    end
    if (uj || ut) begin
      m_v[m][b]   = 1'b1;
      m_j[m][b]   = uj;
      m_tag[m][b] = tagof(upc);
      m_tgt[m][b] = utg;
    end
  endfunction

  function automatic logic [63:0] o_taken(input int m);
    return (m == 1) ? 64'(if1.pred_taken) : 64'(if0.pred_taken);
  endfunction
  function automatic logic [63:0] o_target(input int m);
    return (m == 1) ? 64'(if1.pred_target) : 64'(if0.pred_target);
  endfunction
  function automatic logic [63:0] o_idx(input int m);
    return (m == 1) ? 64'(if1.pred_idx) : 64'(if0.pred_idx);
  endfunction
  function automatic logic [63:0] o_lk(input int m);
    return (m == 1) ? 64'(stat_lk1) : 64'(stat_lk0);
  endfunction
  function automatic logic [63:0] o_mp(input int m);
    return (m == 1) ? 64'(stat_mp1) : 64'(stat_mp0);
  endfunction

  task automatic drive(input int m, input bit len, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input int uidx, input bit uj, input bit ut,
                       input logic [31:0] utg, input bit um);
    if0.lookup_en    = 1'b0;
    if0.update_valid = 1'b0;
    if1.lookup_en    = 1'b0;
    if1.update_valid = 1'b0;
    if (m == 0) begin
      if0.lookup_en = len;  if0.lookup_pc = lpc;  if0.update_valid = uv;
      if0.update_pc = upc;  if0.update_idx = IW'(uidx);  if0.update_is_jump = uj;
      if0.update_taken = ut;  if0.update_target = utg;  if0.update_mispredict = um;
    end else begin
      if1.lookup_en = len;  if1.lookup_pc = lpc;  if1.update_valid = uv;
      if1.update_pc = upc;  if1.update_idx = IW'(uidx);  if1.update_is_jump = uj;
      if1.update_taken = ut;  if1.update_target = utg;  if1.update_mispredict = um;
    end
  endtask

  // One clock of traffic on predictor m: predictions and statistics are
  // compared before the edge, the model is trained after it.
  task automatic cycle(input int m, input bit len, input logic [31:0] lpc, input bit uv,
                       input logic [31:0] upc, input int uidx, input bit uj, input bit ut,
                       input logic [31:0] utg, input bit um);
    drive(m, len, lpc, uv, upc, uidx, uj, ut, utg, um);
    #1;
    model_predict(m, lpc, e_taken, e_target, e_idx);
    last_taken  = o_taken(m) == 64'd1;
    last_target = 32'(o_target(m));
    last_idx    = int'(o_idx(m));
    check($sformatf("m%0d_taken_pc%0h", m, lpc),  o_taken(m),  64'(e_taken));
    check($sformatf("m%0d_target_pc%0h", m, lpc), o_target(m), 64'(e_target));
    check($sformatf("m%0d_idx_pc%0h", m, lpc),    o_idx(m),    64'(e_idx));
    check($sformatf("m%0d_stat_lookups", m),      o_lk(m),     64'(m_lk[m]));
    check($sformatf("m%0d_stat_mispredicts", m),  o_mp(m),     64'(m_mp[m]));
    @(posedge clk);
    if (len) m_lk[m]++;
    if (uv && um) m_mp[m]++;
    if (uv) model_train(m, upc, uidx, uj, ut, utg);
    @(negedge clk);
  endtask

  task automatic peek(input int m, input logic [31:0] pc);
    drive(m, 1'b0, pc, 1'b0, 32'd0, 0, 1'b0, 1'b0, 32'd0, 1'b0);
    #1;
  endtask

  initial begin
    bit          prev_taken;
    bit          prev_mp;
    int          prev_idx;
    int          m;
    logic [31:0] lpc, upc, utg;
    bit          uj, ut;

    model_reset();
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive(0, 1'b0, 32'h0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0, 1'b0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state.
    peek(0, 32'h100);
    check("rst_taken",  if0.pred_taken,  1'b0);
    check("rst_target", if0.pred_target, 32'h104);
    check("rst_idx",    if0.pred_idx,    6'd0);
    check("rst_lk",     stat_lk0,        32'd0);
    check("rst_mp",     stat_mp0,        32'd0);
    cycle(0, 1, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 0);

    // Bimodal: two taken trainings, then two not-taken.
    cycle(0, 1, 32'h100, 1, 32'h100, 0, 0, 1, 32'h80, 1);
    cycle(0, 1, 32'h100, 1, 32'h100, 0, 0, 1, 32'h80, 0);
    peek(0, 32'h100);
    check("bim_taken",  if0.pred_taken,  1'b1);
    check("bim_target", if0.pred_target, 32'h80);
    cycle(0, 1, 32'h100, 1, 32'h100, 0, 0, 0, 32'h80, 1);
    cycle(0, 1, 32'h100, 1, 32'h100, 0, 0, 0, 32'h80, 0);
    peek(0, 32'h100);
    check("bim_nt_taken",  if0.pred_taken,  1'b0);
    check("bim_nt_target", if0.pred_target, 32'h104);

    // JAL: predicted taken although its counter slot is weakly-not-taken.
    cycle(0, 0, 32'h0, 1, 32'h200, 0, 1, 1, 32'h400, 1);
    peek(0, 32'h200);
    check("jal_taken",  if0.pred_taken,  1'b1);
    check("jal_target", if0.pred_target, 32'h400);

    // Aliasing on BTB index 0: 0x100 then 0x200, different tags.
    cycle(0, 1, 32'h100, 1, 32'h100, 0, 0, 1, 32'h80, 1);
    peek(0, 32'h100);
    check("alias_first_taken", if0.pred_taken, 1'b1);
    cycle(0, 1, 32'h200, 1, 32'h200, 0, 0, 1, 32'h300, 1);
    peek(0, 32'h100);
    check("alias_evicted_taken",  if0.pred_taken,  1'b0);
    check("alias_evicted_target", if0.pred_target, 32'h104);
    peek(0, 32'h200);
    check("alias_second_target", if0.pred_target, 32'h300);

    // Same-cycle update and lookup: old prediction now, new one next cycle.
    cycle(0, 1, 32'h100, 1, 32'h100, 0, 0, 1, 32'h90, 1);
    check("same_cycle_old_taken",  64'(last_taken),  64'd0);
    check("same_cycle_old_target", 64'(last_target), 64'h104);
    peek(0, 32'h100);
    check("same_cycle_new_taken",  if0.pred_taken,  1'b1);
    check("same_cycle_new_target", if0.pred_target, 32'h90);

    // Gshare: alternating T/N branch at 0x40, trained one cycle after lookup.
    prev_taken = 1'b0;
    prev_mp    = 1'b0;
    prev_idx   = 0;
    for (int k = 0; k <= 20; k++) begin
      cycle(1, k < 20, 32'h40, k > 0, 32'h40, prev_idx, 0, prev_taken, 32'h20, prev_mp);
      if (k >= 16 && k < 20) check($sformatf("gshare_conv_%0d", k), 64'(last_taken), 64'(k % 2 == 0));
      prev_taken = (k % 2 == 0);
      prev_idx   = last_idx;
      prev_mp    = (e_taken != prev_taken) || (prev_taken && e_target != 32'h20);
    end
    peek(1, 32'h40);
    check("gshare_stat_mp", stat_mp1, 32'(m_mp[1]));
    check("gshare_stat_lk", stat_lk1, 32'd20);

    // Reset asserted while a taken update is presented: nothing is written.
    drive(0, 1'b1, 32'h3C0, 1'b1, 32'h3C0, 48, 1'b0, 1'b1, 32'h500, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    peek(0, 32'h3C0);
    check("rst_upd_taken",  if0.pred_taken,  1'b0);
    check("rst_upd_target", if0.pred_target, 32'h3C4);
    check("rst_upd_lk",     stat_lk0,        32'd0);
    check("rst_upd_mp",     stat_mp0,        32'd0);
    peek(0, 32'h100);
    check("rst_btb_cleared", if0.pred_taken, 1'b0);
    // Counter back at weakly-not-taken: one taken + one not-taken returns to not-taken.
    cycle(0, 1, 32'h100, 1, 32'h100, 0, 0, 1, 32'h80, 1);
    cycle(0, 1, 32'h100, 1, 32'h100, 0, 0, 0, 32'h80, 1);
    peek(0, 32'h100);
    check("rst_cnt_reinit", if0.pred_taken, 1'b0);

    // Random traffic on a small, alias-rich PC set for both predictors.
    for (int n = 0; n < 600; n++) begin
      m   = (n < 300) ? 0 : 1;
      lpc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      upc = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      utg = $urandom & 32'hFFFF_FFFC;
      uj  = ($urandom_range(0, 4) == 0);
      ut  = uj ? 1'b1 : 1'($urandom_range(0, 1));
      cycle(m, $urandom_range(0, 3) != 0, lpc, $urandom_range(0, 2) != 0, upc,
            int'($urandom_range(0, ENT - 1)), uj, ut, utg, 1'($urandom_range(0, 1)));
    end
    peek(0, 32'h0);
    check("rand_m0_lk", stat_lk0, 32'(m_lk[0]));
    check("rand_m0_mp", stat_mp0, 32'(m_mp[0]));
    check("rand_m1_lk", stat_lk1, 32'(m_lk[1]));
    check("rand_m1_mp", stat_mp1, 32'(m_mp[1]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
